serial_word_streamer: RTL and testbench

//  Upstream feeder for the sticky first-one detector. Accepts parallel words over a

---
 rtl/serial_word_streamer.sv | 99 +++++++++
 tb/tb_serial_word_streamer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_streamer.sv
// Parallel-to-serial word streamer with a 1-deep hold buffer and per-bit frame markers.
// Consecutive words stream back to back; din_ready is combinational from the hold buffer state.
module serial_word_streamer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             a,
    output logic             a_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] hold;
    logic             hold_full;

    logic             xfer;
    logic             shifter_free;
    logic [WIDTH-1:0] load_word;
    logic             load_first;
    logic [WIDTH-1:0] load_rest;
    logic             shift_next;
    logic [WIDTH-1:0] shift_rest;
    logic [CNT_W-1:0] cnt_next;

    assign din_ready    = ~hold_full;
    assign busy         = (state == SHIFT) | hold_full;
    assign xfer         = din_valid & din_ready;
    assign shifter_free = (state == IDLE) || (bit_cnt == LAST_CNT);
    assign cnt_next     = CNT_W'(bit_cnt + 1'b1);

    // Held word always wins the shifter over a fresh transfer
    assign load_word  = hold_full ? hold : din;
    assign load_first = MSB_FIRST ? load_word[WIDTH-1] : load_word[0];
    assign load_rest  = MSB_FIRST ? (load_word << 1) : (load_word >> 1);
    assign shift_next = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
    assign shift_rest = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            a           <= IDLE_BIT;
            a_valid     <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
        end else if (shifter_free) begin
            if (hold_full || xfer) begin
                state       <= SHIFT;
                bit_cnt     <= '0;
                shift_reg   <= load_rest;
                hold_full   <= 1'b0;
                a           <= load_first;
                a_valid     <= 1'b1;
                frame_start <= 1'b1;
                frame_last  <= 1'b0;
            end else begin
                state       <= IDLE;
                bit_cnt     <= '0;
                a           <= IDLE_BIT;
                a_valid     <= 1'b0;
                frame_start <= 1'b0;
                frame_last  <= 1'b0;
            end
        end else begin
            bit_cnt     <= cnt_next;
            shift_reg   <= shift_rest;
            a           <= shift_next;
            frame_start <= 1'b0;
            frame_last  <= (cnt_next == LAST_CNT);
            // Word arriving mid-shift parks in the hold buffer
            if (xfer) begin
                hold      <= din;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_streamer.sv
// Bench for serial_word_streamer: directed scenarios plus random traffic against
// a bit-queue reference model (LSB-first and MSB-first instances).
module tb_serial_word_streamer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din0, din1;
    logic         dv0, dv1;
    logic         rdy0, a0, av0, fs0, fl0, busy0;
    logic         rdy1, a1, av1, fs1, fl1, busy1;

    serial_word_streamer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .rst(rst), .din(din0), .din_valid(dv0), .din_ready(rdy0),
        .a(a0), .a_valid(av0), .frame_start(fs0), .frame_last(fl0), .busy(busy0)
    );

    serial_word_streamer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .rst(rst), .din(din1), .din_valid(dv1), .din_ready(rdy1),
        .a(a1), .a_valid(av1), .frame_start(fs1), .frame_last(fl1), .busy(busy1)
    );

    always #5 clk = ~clk;

    logic [5:0] obs0, obs1;
    assign obs0 = {a0, av0, fs0, fl0, busy0, rdy0};
    assign obs1 = {a1, av1, fs1, fl1, busy1, rdy1};

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference: a queue of {bit, first, last} not yet driven; one pops per clock
    logic [2:0] bq[$];
    logic [5:0] exp_vec;
    logic       exp_ready;

    task automatic step(input logic v, input logic [W-1:0] d, input logic r, input bit msb);
        logic [2:0] e;
        logic       ea, ev, efs, efl;
        rst  = r;
        din0 = msb ? '0 : d;
        dv0  = msb ? 1'b0 : v;
        din1 = msb ? d : '0;
        dv1  = msb ? v : 1'b0;
        @(posedge clk);
        {ea, ev, efs, efl} = 4'b0000;
        if (r) begin
            bq.delete();
        end else begin
            if (v && bq.size() < W) begin
                for (int i = 0; i < W; i++)
                    bq.push_back({d[msb ? (W - 1 - i) : i], (i == 0), (i == W - 1)});
            end
            if (bq.size() > 0) begin
                e = bq.pop_front();
                {ea, efs, efl} = e;
                ev = 1'b1;
            end
        end
        exp_ready = (bq.size() < W);
        exp_vec   = {ea, ev, efs, efl, ev | ~exp_ready, exp_ready};
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 8'hFF, 1'b1, 1'b0);
            n_vec++;
            if (obs0 !== 6'b000001 || obs1 !== 6'b000001) begin
                n_err++;
                $display("FAIL reset cyc%0d: got %b/%b want 000001", cyc, obs0, obs1);
            end
        end
    endtask

    task automatic test_single();
        logic [W-1:0] got;
        int           k;
        got = '0;
        k   = 0;
        step(1'b1, 8'h04, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step(1'b0, 8'h00, 1'b0, 1'b0);
            n_vec++;
            if (obs0 !== exp_vec) begin
                n_err++;
                $display("FAIL single cyc%0d: got %b want %b", cyc, obs0, exp_vec);
            end
            if (av0 && k < W) begin
                got[k] = a0;
                k++;
            end
        end
        n_vec++;
        if (got !== 8'h04 || k != W) begin
            n_err++;
            $display("FAIL single_bits: got %h (%0d bits) want 04 (8 bits)", got, k);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got, want;
        int          k;
        want = 16'b1010010100111100;
        got  = '0;
        k    = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 0)      step(1'b1, 8'hA5, 1'b0, 1'b0);
            else if (i == 1) step(1'b1, 8'h3C, 1'b0, 1'b0);
            else             step(1'b0, 8'h00, 1'b0, 1'b0);
            n_vec++;
            if (obs0 !== exp_vec) begin
                n_err++;
                $display("FAIL back_to_back cyc%0d: got %b want %b", cyc, obs0, exp_vec);
            end
            if (av0 && k < 16) begin
                got[15 - k] = a0;
                k++;
            end
        end
        n_vec++;
        if (got !== want || k != 16) begin
            n_err++;
            $display("FAIL b2b_stream: got %b (%0d bits) want %b", got, k, want);
        end
    endtask

    task automatic test_msb_first();
        step(1'b1, 8'h80, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step(1'b0, 8'h00, 1'b0, 1'b1);
            n_vec++;
            if (obs1 !== exp_vec) begin
                n_err++;
                $display("FAIL msb_first cyc%0d: got %b want %b", cyc, obs1, exp_vec);
            end
        end
    endtask

    task automatic test_hold_stall();
        for (int i = 0; i < 20; i++) begin
            if (i == 0)               step(1'b1, 8'hC3, 1'b0, 1'b0);
            else if (i == 1)          step(1'b1, 8'h96, 1'b0, 1'b0);
            else if (i >= 2 && i < 7) step(1'b1, 8'h5A, 1'b0, 1'b0);
            else                      step(1'b0, 8'h00, 1'b0, 1'b0);
            n_vec++;
            if (obs0 !== exp_vec) begin
                n_err++;
                $display("FAIL hold_stall cyc%0d: got %b want %b", cyc, obs0, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_vec++;
        if (obs0 !== exp_vec) begin
            n_err++;
            $display("FAIL reset_mid_pre cyc%0d: got %b want %b", cyc, obs0, exp_vec);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_vec++;
        if (obs0 !== 6'b000001) begin
            n_err++;
            $display("FAIL reset_mid cyc%0d: got %b want 000001", cyc, obs0);
        end
        for (int i = 0; i < 12; i++) begin
            step((i == 0), 8'h01, 1'b0, 1'b0);
            n_vec++;
            if (obs0 !== exp_vec) begin
                n_err++;
                $display("FAIL reset_mid_next cyc%0d: got %b want %b", cyc, obs0, exp_vec);
            end
        end
    endtask

    task automatic test_idle_gap();
        for (int i = 0; i < 22; i++) begin
            step((i == 0) || (i == 11), (i == 0) ? 8'h01 : 8'h02, 1'b0, 1'b0);
            n_vec++;
            if (obs0 !== exp_vec) begin
                n_err++;
                $display("FAIL idle_gap cyc%0d: got %b want %b", cyc, obs0, exp_vec);
            end
        end
    endtask

    task automatic test_random(input bit msb);
        logic         v, r;
        logic [W-1:0] d;
        v = 1'b0;
        d = '0;
        for (int i = 0; i < 600; i++) begin
            // Upstream keeps the offered word stable while it is stalled
            if (!(v && !exp_ready)) begin
                v = ($urandom_range(0, 3) != 0);
                d = W'($urandom);
            end
            r = ($urandom_range(0, 59) == 0);
            step(v, d, r, msb);
            if (r) v = 1'b0;
            n_vec++;
            if ((msb ? obs1 : obs0) !== exp_vec) begin
                n_err++;
                $display("FAIL random msb=%0d cyc%0d: got %b want %b", msb, cyc,
                         msb ? obs1 : obs0, exp_vec);
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        din0 = '0;
        din1 = '0;
        dv0  = 1'b0;
        dv1  = 1'b0;
        exp_ready = 1'b1;
        exp_vec   = 6'b000001;
        test_reset();
        test_single();
        test_back_to_back();
        test_msb_first();
        test_hold_stall();
        test_reset_mid();
        test_idle_gap();
        test_random(1'b0);
        test_reset();
        test_random(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
